// File: rtl/ysyx_23060208_ifu_fetch.sv
// rtl/ysyx_23060208_ifu_fetch.sv - instruction fetch unit, producer side of the IFU->IDU handshake
// One imem read outstanding at a time; EXU redirects squash wrong-path fetches.
module ysyx_23060208_ifu_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [DATA_WIDTH-1:0]     imem_addr,
  input  logic                      imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     imem_rsp_data,
  input  logic                      redirect_valid,
  input  logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
  output logic                      ifu_to_idu_valid,
  input  logic                      idu_allowin,
  output logic [31:0]               ifu_fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   pc, pc_nxt;
  logic                    drop, drop_nxt;
  logic [2*DATA_WIDTH-1:0] bus, bus_nxt;
  logic [31:0]             cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   redirect_target;

  assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);
  assign imem_addr       = pc & ~DATA_WIDTH'(3);
  assign ifu_to_idu_bus  = bus;
  assign ifu_fetch_cnt   = cnt;

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    drop_nxt         = drop;
    bus_nxt          = bus;
    cnt_nxt          = cnt;
    imem_req_valid   = 1'b0;
    ifu_to_idu_valid = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) pc_nxt = redirect_target;
        // A redirect racing an accepted request must squash that request's response.
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          drop_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
          drop_nxt  = 1'b0;
          if (redirect_valid) begin
            pc_nxt = redirect_target;
          end else if (!drop) begin
            bus_nxt   = {pc, imem_rsp_data};
            state_nxt = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_nxt   = redirect_target;
          drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect wins over a pending transfer.
        ifu_to_idu_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          state_nxt = S_REQ;
        end else if (idu_allowin) begin
          pc_nxt    = pc + DATA_WIDTH'(4);
          cnt_nxt   = cnt + 32'd1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      bus   <= '0;
      cnt   <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      bus   <= bus_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A stale response may land in IDLE right after reset; anywhere else outside WAIT is a protocol error.
  a_rsp_in_wait: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (state == S_WAIT || state == S_IDLE))
    else $fatal(1, "imem response outside WAIT");

  a_hold_stable: assert property (@(posedge clock) disable iff (reset)
    ($past(state == S_HOLD && !redirect_valid && !idu_allowin) && !$past(reset)) |-> $stable(bus))
    else $fatal(1, "bus changed while holding");

endmodule

// File: doc/ysyx_23060208_ifu_fetch.md
Name: ysyx_23060208_ifu_fetch

Overview:
- Instruction fetch unit: the producer end of the IFU->IDU valid/allowin handshake.
- Holds the PC and issues one instruction-memory read at a time.
- Delivers {pc, inst} to the IDU on ifu_to_idu_bus.
- Accepts PC redirects from EXU (taken branch, jal/jalr, ecall/mret) and squashes wrong-path fetches.

Parameters:
DATA_WIDTH, 32, PC/instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  DATA_WIDTH  request address (word aligned)
imem_rsp_valid  input  1  read data valid (one response per accepted request, in order)
imem_rsp_data  input  DATA_WIDTH  instruction word
redirect_valid  input  1  EXU redirect strobe (1 cycle)
redirect_pc  input  DATA_WIDTH  redirect target
ifu_to_idu_bus  output  2*DATA_WIDTH  {pc[63:32], inst[31:0]}
ifu_to_idu_valid  output  1  bus holds a valid instruction
idu_allowin  input  1  IDU can accept this cycle
ifu_fetch_cnt  output  32  count of instructions delivered to IDU

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-high; all state updates on posedge clock.
- Reset values:
  - state=IDLE, pc=RESET_PC, drop=0, bus=0, ifu_fetch_cnt=0.
  - imem_req_valid=0, ifu_to_idu_valid=0.
- Reset asserted mid-operation overrides everything. An in-flight memory response arriving after reset release, while in IDLE, is ignored.
- imem_addr = {pc[31:2], 2'b00}. redirect_pc[1:0] is ignored (forced to 0).
- Transfer occurs when ifu_to_idu_valid && idu_allowin. The IDU latches the bus in that cycle.
- Only one request is ever outstanding.
- FSM states:
  - IDLE: outputs idle; next state REQ unconditionally.
  - REQ: imem_req_valid=1.
    - req_ready=1 -> WAIT.
    - redirect without req_ready: pc<=redirect_pc, stay REQ; the request changes address next cycle.
    - redirect with req_ready in the same cycle: old request is accepted; pc<=redirect_pc, drop<=1, -> WAIT.
  - WAIT: imem_req_valid=0.
    - rsp_valid with drop=0 and no redirect: bus<={pc, rsp_data}, -> HOLD.
    - rsp_valid with drop=1: discard the response, drop<=0, -> REQ.
    - redirect without rsp_valid: pc<=redirect_pc, drop<=1, stay WAIT.
    - redirect together with rsp_valid: discard the response, pc<=redirect_pc, drop<=0, -> REQ.
  - HOLD: ifu_to_idu_valid = !redirect_valid (combinational gate; redirect has priority over transfer). The bus is stable while waiting.
    - redirect: discard the held instruction, pc<=redirect_pc, -> REQ; no transfer, counter unchanged.
    - transfer: pc<=pc+4 (mod 2^32), ifu_fetch_cnt+=1 (wraps at 2^32), -> REQ.
    - otherwise: stay HOLD.
- ifu_to_idu_valid is 0 in every state except HOLD.
- Latency: with a 1-cycle memory, the first request goes out in the cycle after IDLE. The request is accepted in REQ, the response arrives in WAIT, and valid rises in the next cycle. Steady throughput is 1 instruction per 3 cycles when idu_allowin=1.
- Wrong-path instructions already inside the IDU are flushed by EXU/IDU logic, not by this block.
- Assertions (simulation only):
  - imem_rsp_valid while not in WAIT (excluding the IDLE-after-reset case) -> $fatal.
  - bus changes in HOLD without a transfer or redirect -> $fatal.

Test Plan:
- Reset release, 1-cycle memory returning 32'h0000_0413, allowin=1 -> imem_addr=0x8000_0000; bus={0x8000_0000, 0x0000_0413} with valid high 1 cycle; next imem_addr=0x8000_0004; ifu_fetch_cnt=1.
- idu_allowin=0 for 5 cycles while in HOLD -> valid stays 1, bus unchanged, no new request, pc unchanged. allowin=1 -> transfer, pc=0x8000_0004.
- redirect_valid with redirect_pc=0x8000_0100 during WAIT, 3-cycle memory latency -> stale response discarded with no valid; next imem_addr=0x8000_0100 and delivered pc=0x8000_0100.
- redirect 0x8000_0200 in HOLD with allowin=1 in the same cycle -> ifu_to_idu_valid=0 that cycle, counter unchanged, next request to 0x8000_0200.
- redirect_pc=0x8000_0102 in REQ with req_ready=0 -> next cycle imem_addr=0x8000_0100.
- reset asserted in WAIT, then memory response returns in IDLE -> response ignored; fetch restarts at 0x8000_0000, counter=0.
